nand_flash_responder: RTL and testbench
=======================================

Name: nand_flash_responder

Overview:
- Synthesizable model of the NAND flash device end of the flash bus: the target that the flash controller drives via CLE/ALE/WEN/REN and IO, answering with RB and read data.
- Implements the 512-byte-page command subset the controller uses:
  - 00h/01h page read (first/second half-page pointer)
  - 80h…10h page program
  - FFh reset
- Page storage is external through a simple synchronous memory port, so the same block serves as both flash A (source) and flash B (destination) in system benches and FPGA bring-up.

Parameters:
- ROW_W, 16, row (page) address width; the address-cycle bytes are truncated to this width.
- T_R, 20, clk cycles RB is held low after read address or page-boundary crossing (≥2).
- T_PROG, 50, clk cycles RB is held low after the 10h program confirm (≥1).
- T_RST, 10, clk cycles RB is held low after FFh (≥1).

Ports:
- clk  in  1  single system clock; all flash strobes are sampled on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- F_IO_IN  in  8  IO bus value as seen at the pad.
- F_IO_OUT  out  8  read data driven toward the pad.
- F_IO_OE  out  1  1 = responder drives the IO bus.
- F_CLE  in  1  command latch enable.
- F_ALE  in  1  address latch enable.
- F_WEN  in  1  write enable, active low; data is latched on its rising edge.
- F_REN  in  1  read enable, active low.
- F_RB  out  1  ready(1)/busy(0).
- mem_addr  out  ROW_W+9  {row, column[8:0]}.
- mem_we  out  1  one-cycle write strobe.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte, valid 1 clk after mem_addr.

Behaviour:
- Reset values:
  - F_IO_OUT=0, F_IO_OE=0, F_RB=1, mem_we=0, mem_addr=0.
  - State IDLE; column = 0; row = 0; half = 0.
- Strobe sampling:
  - F_WEN and F_REN are registered every clk; edges are detected from the previous sample.
  - The controller holds each strobe level for ≥2 clk.
  - On a WEN rise, a byte is latched using the CLE/ALE values sampled in that same cycle.
  - CLE=ALE=1 together: the byte is ignored.
- States: IDLE, ADDR, BUSY_RD, RD_OUT, PG_DATA, BUSY_PG, BUSY_RST.
- Commands (CLE=1 on a WEN rise):
  - 00h/01h in IDLE/RD_OUT/PG_DATA: half ← cmd[0]; mode ← read; go to ADDR with address count 0.
  - 80h: mode ← program; half ← 0; go to ADDR.
  - 10h in PG_DATA: go to BUSY_PG.
  - FFh in any state, including the busy states: go to BUSY_RST.
  - Any other command, or a non-FFh command while busy: ignored, state unchanged.
- ADDR (ALE=1 on a WEN rise), three bytes in order:
  - Byte 1: column[7:0]; column[8] ← half.
  - Byte 2: row[7:0].
  - Byte 3: row[15:8], truncated to ROW_W.
  - After byte 3: read mode → BUSY_RD; program mode → PG_DATA.
  - A command received while in ADDR restarts per the command rules above.
- BUSY_RD / BUSY_PG / BUSY_RST:
  - F_RB=0 from the clk after entry, for exactly T_R / T_PROG / T_RST cycles, then F_RB=1.
  - BUSY_RD exits to RD_OUT. During the last busy cycle, mem_addr={row,column} is issued so the first byte is prefetched.
  - BUSY_PG and BUSY_RST exit to IDLE.
  - BUSY_RST clears column, row and half.
- RD_OUT:
  - While the sampled REN=0: F_IO_OE=1 and F_IO_OUT = prefetched byte. Otherwise F_IO_OE=0.
  - On each REN rise: column+1 and the next byte is prefetched.
  - Column 511→0 wrap: row+1 (wraps at 2^ROW_W), half ← 0, re-enter BUSY_RD for T_R cycles.
- PG_DATA:
  - Each WEN rise with CLE=ALE=0: mem_we=1 for one clk at {row,column} with the latched byte, then column+1.
  - Once column=511 has been written, further data bytes are dropped.
  - 10h with zero data bytes is legal: busy only, no writes.
- F_IO_OE is never 1 outside RD_OUT. It drops in the clk after a REN rise, or immediately when any WEN/CLE/ALE activity is sampled.
- Asynchronous reset mid-operation: immediate return to reset values; no partial mem_we.

Decomposition:
- Shared package: command constants CMD_READ0=00h, CMD_READ1=01h, CMD_PROG=80h, CMD_PROG_CFM=10h, CMD_RESET=FFh; the state enum; PAGE_BYTES=512.
- One natural sub-module, nand_busy_timer: a loadable down-counter driving RB, loaded with T_R/T_PROG/T_RST and reporting done.

Test Plan:
- Reset check: assert rst mid-PG_DATA → F_RB=1, F_IO_OE=0, mem_we=0 within the same cycle; state returns to IDLE.
- Read: preload page 5 byte 0=3Ch, byte 1=A5h; send 00h, addresses 00h,05h,00h → F_RB=0 for exactly 20 clk, then two REN pulses return 3Ch then A5h with F_IO_OE=1 only while REN is low.
- Half-page and wrap: 01h with column FFh, row 7 → first byte read from address 7·512+511; the next REN rise starts a fresh 20-clk busy, and the next byte comes from row 8, column 0.
- Program: 80h, addresses 10h,02h,00h, data 11h,22h,33h, then 10h → mem_we pulses at addresses 0x410, 0x411, 0x412 with 11h/22h/33h; F_RB=0 for 50 clk.
- Reset command: FFh during BUSY_PG → F_RB stays 0 for T_RST=10 clk from the FFh; a following read uses row 0 / column 0 defaults only if re-addressed; 90h is ignored with no state change.
- Program overflow: 515 data bytes after column 0 → exactly 512 mem_we pulses; the last is at column 511.

Source files
------------

// File: rtl/nand_flash_responder_pkg.sv
// Shared definitions for the NAND flash responder:
// command opcodes, page geometry and the FSM state encoding.
package nand_flash_responder_pkg;

   localparam logic [7:0] CMD_READ0    = 8'h00;
   localparam logic [7:0] CMD_READ1    = 8'h01;
   localparam logic [7:0] CMD_PROG     = 8'h80;
   localparam logic [7:0] CMD_PROG_CFM = 8'h10;
   localparam logic [7:0] CMD_RESET    = 8'hFF;

   localparam int PAGE_BYTES = 512;
   localparam int COL_W      = 9;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(PAGE_BYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_BUSY_RD,
      S_RD_OUT,
      S_PG_DATA,
      S_BUSY_PG,
      S_BUSY_RST
   } state_e;

   typedef enum logic {
      M_READ,
      M_PROG
   } mode_e;

endpackage

// File: rtl/nand_busy_timer.sv
// Loadable down-counter that owns the ready/busy pin.
// RB is low while the count is non-zero.
module nand_busy_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] val_i,
   output logic             rb_o,
   output logic             last_o,
   output logic             done_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // next count: reload wins, otherwise count down to zero
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // count and registered ready flag
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         rb_o  <= 1'b1;
      end else begin
         cnt_q <= cnt_d;
         rb_o  <= (cnt_d == '0);
      end
   end

   // done marks the final busy cycle, last the one before it
   assign done_o = (cnt_q == CNT_W'(1));
   assign last_o = (cnt_q == CNT_W'(2));

endmodule

// File: rtl/nand_flash_responder.sv
// NAND flash target: decodes CLE/ALE/WEN/REN bus cycles for the
// 512-byte page read/program/reset subset over an external page memory.
module nand_flash_responder
   import nand_flash_responder_pkg::*;
#(
   parameter int ROW_W  = 16,
   parameter int T_R    = 20,
   parameter int T_PROG = 50,
   parameter int T_RST  = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       F_IO_IN,
   output logic [7:0]       F_IO_OUT,
   output logic             F_IO_OE,
   input  logic             F_CLE,
   input  logic             F_ALE,
   input  logic             F_WEN,
   input  logic             F_REN,
   output logic             F_RB,
   output logic [ROW_W+8:0] mem_addr,
   output logic             mem_we,
   output logic [7:0]       mem_wdata,
   input  logic [7:0]       mem_rdata
);

   localparam int T_MX = (T_R > T_PROG) ?
                         ((T_R > T_RST) ? T_R : T_RST) :
                         ((T_PROG > T_RST) ? T_PROG : T_RST);
   localparam int TW = $clog2(T_MX + 1);

   state_e             state_q;
   mode_e              mode_q;
   logic               half_q;
   logic [COL_W-1:0]   col_q;
   logic [ROW_W-1:0]   row_q;
   logic [7:0]         row_lo_q;
   logic [1:0]         acnt_q;
   logic               full_q;
   logic               wen_q, ren_q;
   logic               oe_q;
   logic [7:0]         dout_q;
   logic               pf0_q, pf1_q;
   logic [ROW_W+8:0]   maddr_q;
   logic               mwe_q;
   logic [7:0]         mwd_q;

   logic               wen_rise, ren_rise;
   logic               cmd_v, adr_v, dat_v;
   logic               busy;
   logic               tmr_load, tmr_last, tmr_done;
   logic [TW-1:0]      tmr_val;

   assign wen_rise = F_WEN & ~wen_q;
   assign ren_rise = F_REN & ~ren_q;
   assign cmd_v    = wen_rise & F_CLE & ~F_ALE;
   assign adr_v    = wen_rise & F_ALE & ~F_CLE;
   assign dat_v    = wen_rise & ~F_CLE & ~F_ALE;
   assign busy     = (state_q == S_BUSY_RD) ||
                     (state_q == S_BUSY_PG) ||
                     (state_q == S_BUSY_RST);

   // busy-timer reload: same priority as the FSM below
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      if (cmd_v && (F_IO_IN == CMD_RESET)) begin
         tmr_load = 1'b1;
         tmr_val  = TW'(T_RST);
      end else if (cmd_v) begin
         if ((state_q == S_PG_DATA) && (F_IO_IN == CMD_PROG_CFM)) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(T_PROG);
         end
      end else if ((state_q == S_ADDR) && adr_v &&
                   (acnt_q == 2'd2) && (mode_q == M_READ)) begin
         tmr_load = 1'b1;
         tmr_val  = TW'(T_R);
      end else if ((state_q == S_RD_OUT) && ren_rise &&
                   (col_q == COL_LAST)) begin
         tmr_load = 1'b1;
         tmr_val  = TW'(T_R);
      end
   end

   nand_busy_timer #(
      .CNT_W (TW)
   ) u_timer (
      .clk_i  (clk),
      .rst_i  (rst),
      .load_i (tmr_load),
      .val_i  (tmr_val),
      .rb_o   (F_RB),
      .last_o (tmr_last),
      .done_o (tmr_done)
   );

   // bus-cycle FSM with registered pad and memory outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         mode_q   <= M_READ;
         half_q   <= 1'b0;
         col_q    <= '0;
         row_q    <= '0;
         row_lo_q <= '0;
         acnt_q   <= '0;
         full_q   <= 1'b0;
         wen_q    <= 1'b1;
         ren_q    <= 1'b1;
         oe_q     <= 1'b0;
         dout_q   <= '0;
         pf0_q    <= 1'b0;
         pf1_q    <= 1'b0;
         maddr_q  <= '0;
         mwe_q    <= 1'b0;
         mwd_q    <= '0;
      end else begin
         wen_q <= F_WEN;
         ren_q <= F_REN;
         mwe_q <= 1'b0;
         pf0_q <= 1'b0;
         pf1_q <= pf0_q;
         if (pf1_q) begin
            dout_q <= mem_rdata;
         end
         oe_q <= (state_q == S_RD_OUT) && !F_REN &&
                 F_WEN && wen_q && !F_CLE && !F_ALE;

         if (cmd_v && (F_IO_IN == CMD_RESET)) begin
            state_q <= S_BUSY_RST;
            col_q   <= '0;
            row_q   <= '0;
            half_q  <= 1'b0;
         end else if (cmd_v) begin
            if (!busy) begin
               unique case (F_IO_IN)
                  CMD_READ0, CMD_READ1: begin
                     half_q  <= F_IO_IN[0];
                     mode_q  <= M_READ;
                     acnt_q  <= '0;
                     state_q <= S_ADDR;
                  end
                  CMD_PROG: begin
                     half_q  <= 1'b0;
                     mode_q  <= M_PROG;
                     acnt_q  <= '0;
                     full_q  <= 1'b0;
                     state_q <= S_ADDR;
                  end
                  CMD_PROG_CFM: begin
                     if (state_q == S_PG_DATA) begin
                        state_q <= S_BUSY_PG;
                     end
                  end
                  default: ;
               endcase
            end
         end else begin
            unique case (state_q)
               S_ADDR: begin
                  if (adr_v) begin
                     acnt_q <= acnt_q + 2'd1;
                     unique case (acnt_q)
                        2'd0: col_q <= {half_q, F_IO_IN};
                        2'd1: row_lo_q <= F_IO_IN;
                        2'd2: begin
                           row_q   <= ROW_W'({F_IO_IN, row_lo_q});
                           state_q <= (mode_q == M_READ) ?
                                      S_BUSY_RD : S_PG_DATA;
                        end
                        default: ;
                     endcase
                  end
               end
               S_BUSY_RD: begin
                  if (tmr_last) begin
                     maddr_q <= {row_q, col_q};
                     pf0_q   <= 1'b1;
                  end
                  if (tmr_done) begin
                     state_q <= S_RD_OUT;
                  end
               end
               S_RD_OUT: begin
                  if (ren_rise) begin
                     if (col_q == COL_LAST) begin
                        col_q   <= '0;
                        row_q   <= row_q + 1'b1;
                        half_q  <= 1'b0;
                        state_q <= S_BUSY_RD;
                     end else begin
                        col_q   <= col_q + 1'b1;
                        maddr_q <= {row_q, col_q + 1'b1};
                        pf0_q   <= 1'b1;
                     end
                  end
               end
               S_PG_DATA: begin
                  if (dat_v && !full_q) begin
                     mwe_q   <= 1'b1;
                     maddr_q <= {row_q, col_q};
                     mwd_q   <= F_IO_IN;
                     col_q   <= col_q + 1'b1;
                     if (col_q == COL_LAST) begin
                        full_q <= 1'b1;
                     end
                  end
               end
               S_BUSY_PG, S_BUSY_RST: begin
                  if (tmr_done) begin
                     state_q <= S_IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign F_IO_OUT  = dout_q;
   assign F_IO_OE   = oe_q;
   assign mem_addr  = maddr_q;
   assign mem_we    = mwe_q;
   assign mem_wdata = mwd_q;

endmodule

// File: tb/tb_nand_flash_responder.sv
// Bench for nand_flash_responder: drives flash bus cycles and checks
// reads, programs and busy timing against a sparse page-memory model.
module tb_nand_flash_responder;

   localparam int ROW_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic [7:0]       io_in, io_out;
   logic             oe, cle, ale, wen, ren, rb;
   logic [ROW_W+8:0] mem_addr;
   logic             mem_we;
   logic [7:0]       mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int wen_cyc = 0;

   logic [7:0]  mem [int unsigned];
   logic [7:0]  ref_mem [int unsigned];
   logic        pre_we = 1'b0;
   int unsigned pre_addr = 0;
   logic [7:0]  pre_data = 8'h00;
   int unsigned ma;

   int unsigned wq_a [$];
   logic [7:0]  wq_d [$];
   logic [7:0]  pd [$];

   nand_flash_responder #(
      .ROW_W(ROW_W), .T_R(20), .T_PROG(50), .T_RST(10)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .F_IO_IN   (io_in),
      .F_IO_OUT  (io_out),
      .F_IO_OE   (oe),
      .F_CLE     (cle),
      .F_ALE     (ale),
      .F_WEN     (wen),
      .F_REN     (ren),
      .F_RB      (rb),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   // cycle counter, stable at negedges
   always @(posedge clk) cyc <= cyc + 1;

   // synchronous page memory with a bench preload port
   always @(posedge clk) begin
      ma = 32'(mem_addr);
      mem_rdata <= mem.exists(ma) ? mem[ma] : 8'h00;
      if (pre_we) mem[pre_addr] = pre_data;
      else if (mem_we) mem[ma] = mem_wdata;
   end

   // record every write strobe
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         wq_a.push_back(32'(mem_addr));
         wq_d.push_back(mem_wdata);
      end
   end

   task automatic tick(int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_at(int unsigned r, int unsigned c);
      int unsigned k;
      k = r * 512 + c;
      return ref_mem.exists(k) ? ref_mem[k] : 8'h00;
   endfunction

   task automatic preload(int unsigned a, logic [7:0] d);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      ref_mem[a] = d;
      tick();
      pre_we = 1'b0;
   endtask

   task automatic bus_wr(logic c, logic a, logic [7:0] d);
      cle = c; ale = a; io_in = d;
      tick();
      wen = 1'b0;
      tick(2);
      wen = 1'b1;
      wen_cyc = cyc;
      tick(2);
      cle = 1'b0; ale = 1'b0;
   endtask

   // expects RB low now (optional) and a busy run of n cycles from the strobe
   task automatic busy_check(string tag, int n, bit chk_low);
      int k;
      k = 0;
      if (chk_low) chk({tag, " rb low"}, 32'(rb), 32'd0);
      while (rb !== 1'b1 && k < 1000) begin
         tick();
         k++;
      end
      chk({tag, " busy len"}, 32'(cyc - wen_cyc - 1), 32'(n));
   endtask

   task automatic ren_pulse(string tag, logic [7:0] e);
      ren = 1'b0;
      tick();
      chk({tag, " oe on"}, 32'(oe), 32'd1);
      chk({tag, " data"}, 32'(io_out), 32'(e));
      tick();
      ren = 1'b1;
      wen_cyc = cyc;
      tick();
      chk({tag, " oe off"}, 32'(oe), 32'd0);
      tick();
   endtask

   task automatic do_read(string tag, int unsigned row, int unsigned col,
                          int n, bit fill);
      int unsigned r, c;
      r = row; c = col;
      if (fill) begin
         for (int i = 0; i < n; i++) begin
            preload(r * 512 + c, 8'($urandom));
            if (c == 511) begin c = 0; r = (r + 1) & 32'hFFFF; end
            else c++;
         end
      end
      bus_wr(1'b1, 1'b0, (col >= 256) ? 8'h01 : 8'h00);
      bus_wr(1'b0, 1'b1, 8'(col));
      bus_wr(1'b0, 1'b1, 8'(row));
      bus_wr(1'b0, 1'b1, 8'(row >> 8));
      busy_check({tag, " tR"}, 20, 1'b1);
      r = row; c = col;
      for (int i = 0; i < n; i++) begin
         ren_pulse(tag, exp_at(r, c));
         if (c == 511) begin
            c = 0;
            r = (r + 1) & 32'hFFFF;
            busy_check({tag, " wrap tR"}, 20, 1'b1);
         end else begin
            c++;
         end
      end
   endtask

   task automatic do_prog(string tag, int unsigned row, int unsigned col,
                          int n);
      int unsigned ea [$];
      logic [7:0]  ed [$];
      logic [7:0]  d;
      int unsigned k;
      wq_a.delete(); wq_d.delete();
      bus_wr(1'b1, 1'b0, 8'h80);
      bus_wr(1'b0, 1'b1, 8'(col));
      bus_wr(1'b0, 1'b1, 8'(row));
      bus_wr(1'b0, 1'b1, 8'(row >> 8));
      for (int i = 0; i < n; i++) begin
         d = (i < pd.size()) ? pd[i] : 8'($urandom);
         bus_wr(1'b0, 1'b0, d);
         if (col + i < 512) begin
            k = row * 512 + col + i;
            ea.push_back(k);
            ed.push_back(d);
            ref_mem[k] = d;
         end
      end
      bus_wr(1'b1, 1'b0, 8'h10);
      busy_check({tag, " tPROG"}, 50, 1'b1);
      chk({tag, " nwrites"}, 32'(wq_a.size()), 32'(ea.size()));
      for (int i = 0; i < ea.size(); i++) begin
         if (i < wq_a.size()) begin
            chk({tag, " waddr"}, wq_a[i], ea[i]);
            chk({tag, " wdata"}, 32'(wq_d[i]), 32'(ed[i]));
         end
      end
   endtask

   initial begin
      int unsigned r, c;
      rst = 1'b1; io_in = 8'h00; cle = 1'b0; ale = 1'b0;
      wen = 1'b1; ren = 1'b1;
      tick(3);
      chk("reset rb", 32'(rb), 32'd1);
      chk("reset oe", 32'(oe), 32'd0);
      chk("reset we", 32'(mem_we), 32'd0);
      chk("reset addr", 32'(mem_addr), 32'd0);
      chk("reset dout", 32'(io_out), 32'd0);
      rst = 1'b0;
      tick(2);

      // directed read of page 5
      preload(5 * 512 + 0, 8'h3C);
      preload(5 * 512 + 1, 8'hA5);
      do_read("rd p5", 5, 0, 2, 1'b0);

      // half-page pointer and page-boundary wrap
      do_read("rd half", 7, 511, 2, 1'b1);
      do_read("rd rowwrap", 16'hFFFF, 510, 3, 1'b1);

      // random reads
      for (int i = 0; i < 3; i++) begin
         r = $urandom_range(0, 65535);
         c = $urandom_range(0, 511);
         do_read("rd rand", r, c, $urandom_range(2, 4), 1'b1);
      end

      // directed program
      pd = '{8'h11, 8'h22, 8'h33};
      do_prog("pg dir", 2, 16'h10, 3);
      pd.delete();
      do_read("rd back dir", 2, 16'h10, 3, 1'b0);

      // zero-byte program
      do_prog("pg empty", 9, 0, 0);

      // random program and read-back
      for (int i = 0; i < 2; i++) begin
         r = $urandom_range(0, 65535);
         c = $urandom_range(0, 249);
         do_prog("pg rand", r, c, 6);
         do_read("rd back", r, c, 6, 1'b0);
      end

      // 90h ignored mid-program, then FFh cuts the program busy
      wq_a.delete(); wq_d.delete();
      bus_wr(1'b1, 1'b0, 8'h80);
      bus_wr(1'b0, 1'b1, 8'h00);
      bus_wr(1'b0, 1'b1, 8'h03);
      bus_wr(1'b0, 1'b1, 8'h00);
      bus_wr(1'b1, 1'b0, 8'h90);
      bus_wr(1'b0, 1'b0, 8'hAA);
      ref_mem[3 * 512] = 8'hAA;
      bus_wr(1'b1, 1'b0, 8'h10);
      chk("ign90 rb", 32'(rb), 32'd0);
      tick(5);
      bus_wr(1'b1, 1'b0, 8'hFF);
      busy_check("rstcmd", 10, 1'b0);
      chk("ign90 nwrites", 32'(wq_a.size()), 32'd1);
      chk("ign90 wdata", 32'(wq_d.size() > 0 ? wq_d[0] : 8'h00),
          32'h0000_00AA);
      do_read("rd after rst", 3, 0, 1, 1'b0);

      // overflow: 515 bytes from column 0 give 512 writes
      r = $urandom_range(0, 65535);
      do_prog("pg ovf", r, 0, 515);
      chk("pg ovf last", wq_a.size() > 0 ? wq_a[wq_a.size() - 1] : 0,
          r * 512 + 511);

      // asynchronous reset while a write strobe is high
      bus_wr(1'b1, 1'b0, 8'h80);
      bus_wr(1'b0, 1'b1, 8'h20);
      bus_wr(1'b0, 1'b1, 8'h04);
      bus_wr(1'b0, 1'b1, 8'h00);
      io_in = 8'h77;
      tick();
      wen = 1'b0;
      tick(2);
      wen = 1'b1;
      @(posedge clk);
      #1;
      chk("arst we before", 32'(mem_we), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("arst we", 32'(mem_we), 32'd0);
      chk("arst rb", 32'(rb), 32'd1);
      chk("arst oe", 32'(oe), 32'd0);
      chk("arst addr", 32'(mem_addr), 32'd0);
      tick(2);
      rst = 1'b0;
      tick(2);
      wq_a.delete(); wq_d.delete();
      bus_wr(1'b0, 1'b0, 8'h99);
      bus_wr(1'b1, 1'b0, 8'h10);
      tick(3);
      chk("arst idle nwrites", 32'(wq_a.size()), 32'd0);
      chk("arst idle rb", 32'(rb), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
